// File: rtl/cnn_sdiv_pkg.sv
// Shared widths, saturation limits and FSM state encoding for the
// 20s / 6s sequential signed divider.
package cnn_sdiv_pkg;

    localparam int DIN0_W = 20;
    localparam int DIN1_W = 6;
    localparam int QUOT_W = 14;
    localparam int REM_W  = 6;
    localparam int CNT_W  = 5;

    localparam logic [CNT_W-1:0] ITER_LAST = 5'(DIN0_W - 1);

    localparam logic signed [QUOT_W-1:0] QMAX = 14'sh1fff;
    localparam logic signed [QUOT_W-1:0] QMIN = 14'sh2000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cnn_udiv_step.sv
// One restoring division step on magnitudes: shift the next dividend bit
// into the partial remainder and subtract the divisor when it fits.
module cnn_udiv_step
    import cnn_sdiv_pkg::*;
(
    input  logic [DIN1_W-1:0] prem,
    input  logic              dbit,
    input  logic [DIN1_W-1:0] dmag,
    output logic [DIN1_W-1:0] nrem,
    output logic              qbit
);

    logic [DIN1_W:0] shifted;
    logic [DIN1_W:0] diff;

    // Trial subtraction; the partial remainder is always below the divisor,
    // so the restored or reduced value fits back into DIN1_W bits.
    always_comb begin
        shifted = {prem, dbit};
        diff    = shifted - {1'b0, dmag};
        qbit    = (shifted >= {1'b0, dmag});
        nrem    = qbit ? diff[DIN1_W-1:0] : shifted[DIN1_W-1:0];
    end

endmodule

// File: rtl/cnn_sdiv_20s_6s_seq.sv
// Sequential signed divider: 20-bit dividend / 6-bit divisor giving a
// saturating 14-bit quotient and a 6-bit remainder, one quotient bit per
// cycle, with start/ready/done handshake and a global clock enable.
// Optional build macro: CNN_SDIV_ROUND_EN (round-to-nearest, ties away
// from zero; default build truncates toward zero).
module cnn_sdiv_20s_6s_seq
    import cnn_sdiv_pkg::*;
(
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     ce,
    input  logic                     start,
    input  logic signed [DIN0_W-1:0] din0,
    input  logic signed [DIN1_W-1:0] din1,
    output logic                     ready,
    output logic                     done,
    output logic signed [QUOT_W-1:0] quot,
    output logic signed [REM_W-1:0]  rem,
    output logic                     ovf,
    output logic                     dbz
);

    state_t state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              accept;

    logic [DIN0_W-1:0] dvd;
    logic [DIN1_W-1:0] prem, dmag, nrem;
    logic              qbit, qneg, rneg, zdiv;

    logic                     rnd;
    logic [DIN0_W:0]          qmag;
    logic signed [DIN0_W+1:0] qs;
    logic [QUOT_W:0]          satv;
    logic signed [REM_W-1:0]  rem_m, rem_s, fr;
    logic signed [QUOT_W-1:0] fq;
    logic                     fo;

    // Two's-complement magnitude; the most negative value maps onto its
    // correct unsigned pattern, so no extra bit is needed.
    function automatic logic [DIN0_W-1:0] mag0(input logic signed [DIN0_W-1:0] v);
        return v[DIN0_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [DIN1_W-1:0] mag1(input logic signed [DIN1_W-1:0] v);
        return v[DIN1_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Clamp the signed quotient into QUOT_W bits; MSB of the result flags saturation.
    function automatic logic [QUOT_W:0] sat_q(input logic signed [DIN0_W+1:0] v);
        logic signed [DIN0_W+1:0] hi, lo;
        hi = 22'(QMAX);
        lo = 22'(QMIN);
        if (v > hi)      return {1'b1, QMAX};
        else if (v < lo) return {1'b1, QMIN};
        else             return {1'b0, v[QUOT_W-1:0]};
    endfunction

    assign accept = start & ready & ce;

    cnn_udiv_step u_step (
        .prem (prem),
        .dbit (dvd[DIN0_W-1]),
        .dmag (dmag),
        .nrem (nrem),
        .qbit (qbit)
    );

    // Next-state and handshake decode; a zero divisor skips the iteration phase.
    always_comb begin
        state_nxt = state;
        ready     = (state == IDLE) || (state == DONE);
        done      = (state == DONE);
        case (state)
            IDLE, DONE: begin
                if (accept)             state_nxt = (din1 == '0) ? FIX : CALC;
                else if (state == DONE) state_nxt = IDLE;
            end
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and iteration counter, frozen while ce is low.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (ce) begin
            state <= state_nxt;
            if (accept)             cnt <= ITER_LAST;
            else if (state == CALC) cnt <= cnt - 1'b1;
        end
    end

    // Operand capture on accept, then shift one quotient bit in per CALC cycle.
    always_ff @(posedge ap_clk) begin
        if (ce) begin
            if (accept) begin
                dvd  <= mag0(din0);
                prem <= '0;
                dmag <= mag1(din1);
                qneg <= din0[DIN0_W-1] ^ din1[DIN1_W-1];
                rneg <= din0[DIN0_W-1];
                zdiv <= (din1 == '0);
            end else if (state == CALC) begin
                dvd  <= {dvd[DIN0_W-2:0], qbit};
                prem <= nrem;
            end
        end
    end

    // Sign restoration, optional rounding and saturation of the final result.
    always_comb begin
`ifdef CNN_SDIV_ROUND_EN
        rnd   = ({prem, 1'b0} >= {1'b0, dmag});
        rem_m = rnd ? $signed(prem - dmag) : $signed(prem);
`else
        rnd   = 1'b0;
        rem_m = $signed(prem);
`endif
        qmag  = {1'b0, dvd} + {{DIN0_W{1'b0}}, rnd};
        qs    = qneg ? -$signed({1'b0, qmag}) : $signed({1'b0, qmag});
        rem_s = rneg ? -rem_m : rem_m;
        satv  = sat_q(qs);
        if (zdiv) begin
            fq = rneg ? QMIN : QMAX;
            fo = 1'b1;
            fr = '0;
        end else begin
            fq = $signed(satv[QUOT_W-1:0]);
            fo = satv[QUOT_W];
            fr = rem_s;
        end
    end

    // Result registers update only at the end of FIX and hold until the next one.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            quot <= '0;
            rem  <= '0;
            ovf  <= 1'b0;
            dbz  <= 1'b0;
        end else if (ce && state == FIX) begin
            quot <= fq;
            rem  <= fr;
            ovf  <= fo;
            dbz  <= zdiv;
        end
    end

endmodule

// File: tb/tb_cnn_sdiv_20s_6s_seq.sv
// Self-checking bench for cnn_sdiv_20s_6s_seq: directed corner cases,
// handshake/stall/reset scenarios and randomized operands against an
// integer-arithmetic reference model.
module tb_cnn_sdiv_20s_6s_seq;

    logic               ap_clk = 1'b0;
    logic               ap_rst, ce, start;
    logic signed [19:0] din0;
    logic signed [5:0]  din1;
    logic               ready, done, ovf, dbz;
    logic signed [13:0] quot;
    logic signed [5:0]  rem;

    int checks = 0;
    int errors = 0;
    int hq = 0;

    always #5 ap_clk = ~ap_clk;

    cnn_sdiv_20s_6s_seq dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .ce     (ce),
        .start  (start),
        .din0   (din0),
        .din1   (din1),
        .ready  (ready),
        .done   (done),
        .quot   (quot),
        .rem    (rem),
        .ovf    (ovf),
        .dbz    (dbz)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: C-style integer division, optional nearest rounding, then clamp.
    function automatic void model(input int a, input int b,
                                  output int q, output int r, output int o, output int z);
        z = 0;
        o = 0;
        if (b == 0) begin
            z = 1;
            o = 1;
            q = (a < 0) ? -8192 : 8191;
            r = 0;
            return;
        end
        q = a / b;
        r = a % b;
`ifdef CNN_SDIV_ROUND_EN
        if (2 * (r < 0 ? -r : r) >= (b < 0 ? -b : b)) begin
            q = q + (((a < 0) != (b < 0)) ? -1 : 1);
            r = a - q * b;
        end
`endif
        if (q > 8191) begin
            q = 8191;
            o = 1;
        end else if (q < -8192) begin
            q = -8192;
            o = 1;
        end
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        chk("ready_wait", ready, 1);
    endtask

    task automatic check_result(input string tag, input int a, input int b);
        int q, r, o, z;
        model(a, b, q, r, o, z);
        chk({tag, "_quot"}, quot, q);
        chk({tag, "_rem"}, rem, r);
        chk({tag, "_ovf"}, ovf, o);
        chk({tag, "_dbz"}, dbz, z);
        chk({tag, "_ready"}, ready, 1);
        hq = q;
    endtask

    // One operation; optional garbage start/operands while busy must be ignored.
    task automatic run_op(input int a, input int b, input bit garbage);
        int lat = 0;
        bit seen = 0;
        wait_ready();
        din0  = 20'(a);
        din1  = 6'(b);
        start = 1'b1;
        while (!seen && lat < 60) begin
            @(negedge ap_clk);
            lat++;
            if (done) seen = 1;
            else begin
                chk("hold_quot", quot, hq);
                if (garbage) begin
                    start = 1'($urandom_range(0, 1));
                    din0  = 20'($urandom);
                    din1  = 6'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", lat, (b == 0) ? 2 : 22);
        check_result("op", a, b);
    endtask

    initial begin
        int lat, act;
        bit seen;
        logic signed [13:0] frz;

        ap_rst = 1'b1;
        ce     = 1'b1;
        start  = 1'b0;
        din0   = '0;
        din1   = '0;
        repeat (3) @(negedge ap_clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_dbz", dbz, 0);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        // Directed corners
        run_op(-1000, 7, 0);
        run_op(-524288, -32, 0);
        run_op(524287, 1, 0);
        run_op(100, 0, 0);
        run_op(-5, 0, 0);
        run_op(24573, 3, 0);
        run_op(24576, 3, 0);
        run_op(-24576, 3, 0);
        run_op(-24579, 3, 0);
        run_op(-524288, 1, 0);
        run_op(3, 5, 1);
        run_op(-3, 5, 1);

        // Back-to-back with start held through DONE
        wait_ready();
        din0 = 20'(8190); din1 = 6'(2); start = 1'b1;
        lat = 0; seen = 0;
        while (!seen && lat < 60) begin
            @(negedge ap_clk); lat++;
            if (done) seen = 1;
        end
        chk("b2b1_seen", seen, 1);
        chk("b2b1_latency", lat, 22);
        check_result("b2b1", 8190, 2);
        din0 = -20'sd77; din1 = 6'sd5;
        @(negedge ap_clk);
        chk("b2b_done_drop", done, 0);
        start = 1'b0;
        lat = 1; seen = 0;
        while (!seen && lat < 60) begin
            @(negedge ap_clk); lat++;
            if (done) seen = 1;
        end
        chk("b2b2_seen", seen, 1);
        chk("b2b2_latency", lat, 22);
        check_result("b2b2", -77, 5);

        // Clock-enable toggling: count only enabled edges
        @(negedge ap_clk);
        wait_ready();
        din0 = 20'(30); din1 = -6'sd4; start = 1'b1; ce = 1'b1;
        act = 0; lat = 0; seen = 0;
        while (!seen && lat < 120) begin
            @(negedge ap_clk); lat++;
            start = 1'b0;
            if (done) seen = 1;
            else begin
                chk("ce_hold_quot", quot, hq);
                ce = ~ce;
                if (ce) act++;
            end
        end
        chk("ce_seen", seen, 1);
        chk("ce_active_edges", act, 21);
        check_result("ce", 30, -4);
        ce  = 1'b0;
        frz = quot;
        repeat (3) begin
            @(negedge ap_clk);
            chk("ce_frozen_done", done, 1);
            chk("ce_frozen_quot", quot, frz);
        end
        ce = 1'b1;
        @(negedge ap_clk);
        chk("ce_release_done", done, 0);

        // Reset in the middle of CALC
        wait_ready();
        din0 = 20'(100); din1 = 6'(3); start = 1'b1;
        @(negedge ap_clk);
        start = 1'b0;
        repeat (9) @(negedge ap_clk);
        chk("pre_rst_busy", ready, 0);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_quot", quot, 0);
        chk("mid_rst_rem", rem, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_dbz", dbz, 0);
        ap_rst = 1'b0;
        hq = 0;
        run_op(9, 3, 0);

        // Randomized operands
        for (int i = 0; i < 40; i++) begin
            int a, b;
            a = int'($urandom_range(0, 1048575)) - 524288;
            b = int'($urandom_range(0, 63)) - 32;
            if (i % 10 == 3) b = 0;
            run_op(a, b, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
